// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: engine states, SPI memory opcodes, frame length and the 48-bit frame builder
package spi_mem_pkg;
  typedef enum logic [1:0] {IDLE, XFER, CS_HOLD, WAIT_REL} state_t;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam int FRAME_BITS = 48;
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic we, input logic flash, input logic [15:0] addr, input logic [15:0] wdata);
    return {we ? OP_WRITE : OP_READ, flash ? {12'h000, addr[11:0]} : {8'h00, addr}, we ? {wdata[7:0], wdata[15:8]} : 16'h0000};
  endfunction
endpackage

// File: rtl/spi_mem_shifter.sv
// spi_mem_shifter: mode-0 SCLK divider + 48-bit MSB-first shifter; start loads frame, done marks the last falling edge, rx holds the last 16 MISO bits
module spi_mem_shifter import spi_mem_pkg::*; #(
  parameter int CLK_DIV = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  done,
  output logic [15:0]           rx
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic active_q, active_d, sclk_q, sclk_d, tick;
  logic [DW-1:0] div_q, div_d;
  logic [5:0] bit_q, bit_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [15:0] rx_q, rx_d;
  always_comb begin
    tick = active_q && div_q == DW'(CLK_DIV - 1);
    done = tick && sclk_q && bit_q == 6'(FRAME_BITS - 1);
    active_d = start | (active_q & ~done);
    div_d = (start | tick) ? '0 : active_q ? div_q + 1'b1 : div_q;
    sclk_d = start ? 1'b0 : tick ? ~sclk_q : sclk_q;
    bit_d = start ? '0 : (tick & sclk_q) ? bit_q + 1'b1 : bit_q;
    sr_d = start ? frame : done ? '0 : (tick & sclk_q) ? sr_q << 1 : sr_q;
    rx_d = (tick & ~sclk_q) ? {rx_q[14:0], miso} : rx_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      sclk_q <= 1'b0;
      div_q <= '0;
      bit_q <= '0;
      sr_q <= '0;
      rx_q <= '0;
    end else begin
      active_q <= active_d;
      sclk_q <= sclk_d;
      div_q <= div_d;
      bit_q <= bit_d;
      sr_q <= sr_d;
      rx_q <= rx_d;
    end
  end
  assign sclk = sclk_q;
  assign mosi = sr_q[FRAME_BITS-1];
  assign rx = rx_q;
endmodule

// File: rtl/spi_mem_engine.sv
// spi_mem_engine: hub word requests (mem_*) -> one mode-0 SPI frame to SRAM/Flash (spi_*), ready pulse + rdata back, busy interlock with the peripheral engine
module spi_mem_engine import spi_mem_pkg::*; #(
  parameter int CLK_DIV = 1,
  parameter int MIN_CS_HIGH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  input  logic        mem_cs_select,
  output logic [15:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_busy,
  input  logic        periph_busy,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_ram_cs_n,
  output logic        spi_flash_cs_n
);
  localparam int CW = $clog2(MIN_CS_HIGH + 1) + 1;
  state_t state_q, state_d;
  logic ram_cs_n_q, ram_cs_n_d, flash_cs_n_q, flash_cs_n_d, ready_q, ready_d, busy_q, busy_d, we_q, we_d;
  logic [15:0] rdata_q, rdata_d, rx;
  logic [CW-1:0] gap_q, gap_d;
  logic [FRAME_BITS-1:0] frame;
  logic grant, drop, start, done;
  spi_mem_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk(clk),
    .reset(reset),
    .start(start),
    .frame(frame),
    .miso(spi_miso),
    .sclk(spi_sclk),
    .mosi(spi_mosi),
    .done(done),
    .rx(rx)
  );
  always_comb begin
    grant = state_q == IDLE && mem_req && !periph_busy && gap_q >= CW'(MIN_CS_HIGH);
    drop = mem_we & mem_cs_select;
    start = grant & ~drop;
    frame = build_frame(mem_we, mem_cs_select, mem_addr, mem_wdata);
    gap_d = !(ram_cs_n_q && flash_cs_n_q) ? '0 : gap_q >= CW'(MIN_CS_HIGH) ? gap_q : gap_q + 1'b1;
    state_d = state_q;
    ram_cs_n_d = ram_cs_n_q;
    flash_cs_n_d = flash_cs_n_q;
    ready_d = 1'b0;
    busy_d = busy_q;
    we_d = we_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (grant) begin
        state_d = drop ? WAIT_REL : XFER;
        ready_d = drop;
        busy_d = ~drop;
        ram_cs_n_d = drop | mem_cs_select;
        flash_cs_n_d = drop | ~mem_cs_select;
        we_d = mem_we;
      end
      XFER: if (done) begin
        state_d = CS_HOLD;
        ram_cs_n_d = 1'b1;
        flash_cs_n_d = 1'b1;
        ready_d = 1'b1;
        busy_d = 1'b0;
        rdata_d = we_q ? rdata_q : {rx[7:0], rx[15:8]};
      end
      CS_HOLD: state_d = WAIT_REL;
      default: if (!mem_req) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ram_cs_n_q <= 1'b1;
      flash_cs_n_q <= 1'b1;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
      we_q <= 1'b0;
      rdata_q <= '0;
      gap_q <= CW'(MIN_CS_HIGH);
    end else begin
      state_q <= state_d;
      ram_cs_n_q <= ram_cs_n_d;
      flash_cs_n_q <= flash_cs_n_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
      we_q <= we_d;
      rdata_q <= rdata_d;
      gap_q <= gap_d;
    end
  end
  assign mem_busy = busy_q | start;
  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign spi_ram_cs_n = ram_cs_n_q;
  assign spi_flash_cs_n = flash_cs_n_q;
endmodule

// File: tb/tb_spi_mem_engine.sv
// tb_spi_mem_engine: table + random transactions on CLK_DIV=1 and CLK_DIV=2 engines against a frame-level SPI slave model
module tb_spi_mem_engine;
  localparam int MINH = 2;
  typedef struct {
    int d;
    bit w, f;
    logic [15:0] a, wdat, rsp;
    int pb, hold;
    logic [47:0] frame;
    int lat, cs;
    logic [15:0] rd;
  } vec_t;
  logic clk = 1'b0, reset;
  logic [1:0] req, we, sel, pbusy, miso;
  logic [15:0] addr [2], wd [2];
  wire [1:0] rdy, busy, sclk, mosi, rcs, fcs;
  wire [15:0] rdata [2];
  int checks = 0, errors = 0;
  int run_hi [2] = '{100, 100};
  logic [15:0] last_rd [2];
  string tag;
  vec_t tbl [8];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    spi_mem_engine #(.CLK_DIV(g + 1), .MIN_CS_HIGH(MINH)) dut (
      .clk(clk),
      .reset(reset),
      .mem_req(req[g]),
      .mem_we(we[g]),
      .mem_addr(addr[g]),
      .mem_wdata(wd[g]),
      .mem_cs_select(sel[g]),
      .mem_rdata(rdata[g]),
      .mem_ready(rdy[g]),
      .mem_busy(busy[g]),
      .periph_busy(pbusy[g]),
      .spi_sclk(sclk[g]),
      .spi_mosi(mosi[g]),
      .spi_miso(miso[g]),
      .spi_ram_cs_n(rcs[g]),
      .spi_flash_cs_n(fcs[g])
    );
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
    end
  endtask
  function automatic logic [47:0] model_frame(input bit w, input bit f, input logic [15:0] a, input logic [15:0] d);
    logic [23:0] ad;
    ad = f ? 24'(a % 16'h1000) : 24'(a);
    return {(w ? 8'h02 : 8'h03), ad, (w ? {d[7:0], d[15:8]} : 16'h0000)};
  endfunction
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rcs[i] && fcs[i]) run_hi[i]++;
      else begin
        if (run_hi[i] > 0) chk("cs_high_gap", 64'(run_hi[i] >= MINH), 64'd1);
        run_hi[i] = 0;
      end
    end
  end
  task automatic run(input vec_t v);
    int cd, rd_cyc, cs_first, npulse, cslow, other, nrise, bad_busy, bad_mosi, bad_per, last_rise, budget;
    bit g_busy, pscl, pmosi, pcs, cs_now, done;
    logic [47:0] got, resp;
    logic [15:0] rd_at;
    cd = v.d + 1;
    rd_cyc = -1; cs_first = -1; npulse = 0; cslow = 0; other = 0; nrise = 0;
    bad_busy = 0; bad_mosi = 0; bad_per = 0; last_rise = -1;
    g_busy = 0; pscl = 0; pmosi = 0; pcs = 1; done = 0;
    got = '0;
    resp = {32'h0, v.rsp[7:0], v.rsp[15:8]};
    rd_at = 'x;
    budget = v.pb + v.lat + v.hold + 8;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (c == 0) begin
        we[v.d] = v.w; sel[v.d] = v.f; addr[v.d] = v.a; wd[v.d] = v.wdat;
      end
      req[v.d] = !(rd_cyc >= 0 && c > rd_cyc + v.hold);
      done = !req[v.d];
      pbusy[v.d] = c < v.pb;
      #1;
      cs_now = v.f ? fcs[v.d] : rcs[v.d];
      if (c < v.pb && (busy[v.d] || !rcs[v.d] || !fcs[v.d])) bad_busy++;
      if (c == v.pb) g_busy = busy[v.d];
      if (!cs_now) begin
        cslow++;
        if (cs_first < 0) cs_first = c;
        if (!busy[v.d]) bad_busy++;
      end
      if (!(v.f ? rcs[v.d] : fcs[v.d])) other++;
      if (rdy[v.d]) begin
        npulse++;
        if (rd_cyc < 0) begin rd_cyc = c; rd_at = rdata[v.d]; end
      end
      if (rd_cyc >= 0 && busy[v.d]) bad_busy++;
      if (sclk[v.d] && !pscl) begin
        nrise++;
        if (!cs_now) got = {got[46:0], mosi[v.d]};
        if (last_rise >= 0 && c - last_rise != 2 * cd) bad_per++;
        last_rise = c;
      end
      if (!cs_now && !pcs && mosi[v.d] != pmosi && !(pscl && !sclk[v.d])) bad_mosi++;
      miso[v.d] = (!cs_now && nrise < 48) ? resp[47 - nrise] : 1'b0;
      pscl = sclk[v.d]; pmosi = mosi[v.d]; pcs = cs_now;
    end
    req[v.d] = 1'b0;
    pbusy[v.d] = 1'b0;
    chk("ready_cycle", 64'(rd_cyc), 64'(v.pb + v.lat));
    chk("ready_pulses", 64'(npulse), 64'd1);
    chk("grant_busy", 64'(g_busy), 64'(!(v.w && v.f)));
    chk("cs_low_cycles", 64'(cslow), 64'(v.cs));
    chk("cs_first", 64'(cs_first), 64'(v.cs != 0 ? v.pb + 1 : -1));
    chk("other_cs", 64'(other), 64'd0);
    chk("sclk_rises", 64'(nrise), 64'(v.cs != 0 ? 48 : 0));
    chk("mosi_frame", 64'(got), 64'(v.frame));
    chk("busy_rules", 64'(bad_busy), 64'd0);
    chk("mosi_stable", 64'(bad_mosi), 64'd0);
    chk("sclk_period", 64'(bad_per), 64'd0);
    chk("rdata_at_ready", 64'(rd_at), 64'(v.rd));
    chk("rdata_held", 64'(rdata[v.d]), 64'(v.rd));
    last_rd[v.d] = v.rd;
  endtask
  initial begin
    vec_t v;
    int n;
    tbl[0] = '{0, 1, 0, 16'h0010, 16'h1234, 16'h0000, 0, 0, 48'h02_000010_3412, 97, 96, 16'h0000};
    tbl[1] = '{0, 0, 0, 16'h0020, 16'h0000, 16'hCDAB, 0, 0, 48'h03_000020_0000, 97, 96, 16'hCDAB};
    tbl[2] = '{1, 0, 1, 16'hE123, 16'h0000, 16'h5A6B, 0, 0, 48'h03_000123_0000, 193, 192, 16'h5A6B};
    tbl[3] = '{0, 0, 0, 16'h1357, 16'h0000, 16'h2468, 20, 0, 48'h03_001357_0000, 97, 96, 16'h2468};
    tbl[4] = '{0, 1, 1, 16'hBEEF, 16'hFFFF, 16'h0000, 0, 0, 48'h0, 1, 0, 16'h2468};
    tbl[5] = '{0, 1, 0, 16'hFFFF, 16'hA55A, 16'h0000, 0, 10, 48'h02_00FFFF_5AA5, 97, 96, 16'h2468};
    tbl[6] = '{0, 0, 1, 16'hFFFF, 16'h0000, 16'h0180, 0, 0, 48'h03_000FFF_0000, 97, 96, 16'h0180};
    tbl[7] = '{1, 1, 1, 16'h0000, 16'h7777, 16'h0000, 3, 0, 48'h0, 1, 0, 16'h5A6B};
    req = '0; we = '0; sel = '0; pbusy = '0; miso = '0;
    addr = '{16'h0, 16'h0}; wd = '{16'h0, 16'h0};
    last_rd = '{16'h0, 16'h0};
    reset = 1'b1;
    tag = "reset";
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("ram_cs_n", 64'(rcs[i]), 64'd1);
      chk("flash_cs_n", 64'(fcs[i]), 64'd1);
      chk("sclk", 64'(sclk[i]), 64'd0);
      chk("mosi", 64'(mosi[i]), 64'd0);
      chk("ready", 64'(rdy[i]), 64'd0);
      chk("busy", 64'(busy[i]), 64'd0);
      chk("rdata", 64'(rdata[i]), 64'd0);
    end
    for (int i = 0; i < 8; i++) begin
      tag = $sformatf("vec%0d", i);
      run(tbl[i]);
    end
    tag = "midreset";
    @(negedge clk);
    we[0] = 1'b0; sel[0] = 1'b0; addr[0] = 16'h0042; req[0] = 1'b1;
    repeat (41) @(negedge clk);
    chk("cs_before_reset", 64'(rcs[0]), 64'd0);
    reset = 1'b1; req[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ram_cs_n", 64'(rcs[0]), 64'd1);
    chk("flash_cs_n", 64'(fcs[0]), 64'd1);
    chk("sclk", 64'(sclk[0]), 64'd0);
    chk("ready", 64'(rdy[0]), 64'd0);
    chk("busy", 64'(busy[0]), 64'd0);
    chk("rdata", 64'(rdata[0]), 64'd0);
    n = 0;
    repeat (4) begin
      @(negedge clk);
      #1;
      n += int'(rdy[0]) + int'(!rcs[0]);
    end
    chk("quiet_after_reset", 64'(n), 64'd0);
    last_rd[0] = 16'h0000;
    tag = "post_reset";
    run('{0, 0, 0, 16'h00C3, 16'h0000, 16'h9E71, 0, 0, 48'h03_0000C3_0000, 97, 96, 16'h9E71});
    for (int i = 0; i < 24; i++) begin
      tag = $sformatf("rand%0d", i);
      v.d = int'($urandom_range(1, 0));
      v.w = 1'($urandom);
      v.f = 1'($urandom);
      v.a = 16'($urandom);
      v.wdat = 16'($urandom);
      v.rsp = 16'($urandom);
      v.pb = int'($urandom_range(4, 0));
      v.hold = int'($urandom_range(3, 0));
      v.frame = (v.w && v.f) ? 48'h0 : model_frame(v.w, v.f, v.a, v.wdat);
      v.cs = (v.w && v.f) ? 0 : 96 * (v.d + 1);
      v.lat = v.cs + 1;
      v.rd = v.w ? last_rd[v.d] : v.rsp;
      run(v);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
